// File: rtl/fir_inverse_dec.sv
// Recovers x[n] from a 4-tap FIR output: subtract C1..C3 times history with one multiplier, then restoring-divide by C0.
// Define FIR_INV_STICKY_ERR_EN to make ERR accumulate across samples until RST or CLR.
module fir_inverse_dec #(
    parameter int SIZE = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [2*SIZE+1:0] Y_IN,
    input  logic [SIZE:0]     C0,
    input  logic [SIZE:0]     C1,
    input  logic [SIZE:0]     C2,
    input  logic [SIZE:0]     C3,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [SIZE-1:0]   X_OUT,
    output logic              ERR
);
    localparam int RW = 2*SIZE+3;
    localparam int CW = $clog2(SIZE+1);

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_CHK, S_DIV, S_HOLD} state_t;

    state_t               state_q, state_d;
    logic signed [RW-1:0] r_q, r_d;
    logic [SIZE:0]        c_q [4];
    logic [SIZE:0]        c_d [4];
    logic [SIZE-1:0]      h_q [3];
    logic [SIZE-1:0]      h_d [3];
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*SIZE-1:0]    div_q, div_d;
    logic [SIZE-1:0]      q_q, q_d;
    logic [SIZE-1:0]      x_q, x_d;
    logic                 err_q, err_d;

    logic [SIZE:0]        mul_c;
    logic [SIZE-1:0]      mul_h;
    logic [2*SIZE:0]      prod;
    logic                 ge;
    logic [RW-2:0]        rem_nx;

    // Shared multiplier: MAC step k uses Ck and hk, selected by the step counter.
    always_comb begin
        mul_c = c_q[1];
        mul_h = h_q[0];
        if (cnt_q == CW'(1)) begin
            mul_c = c_q[2];
            mul_h = h_q[1];
        end else if (cnt_q == CW'(2)) begin
            mul_c = c_q[3];
            mul_h = h_q[2];
        end
        prod   = {{SIZE{1'b0}}, mul_c} * {{(SIZE+1){1'b0}}, mul_h};
        ge     = r_q[RW-2:0] >= {2'b00, div_q};
        rem_nx = ge ? (r_q[RW-2:0] - {2'b00, div_q}) : r_q[RW-2:0];
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        q_d     = q_q;
        x_d     = x_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    r_d    = $signed({1'b0, Y_IN});
                    c_d[0] = C0;
                    c_d[1] = C1;
                    c_d[2] = C2;
                    c_d[3] = C3;
                    cnt_d  = '0;
`ifndef FIR_INV_STICKY_ERR_EN
                    err_d  = 1'b0;
`endif
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                r_d   = r_q - $signed({2'b00, prod});
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(2)) state_d = S_CHK;
            end
            S_CHK: begin
                cnt_d   = '0;
                div_d   = {c_q[0], {(SIZE-1){1'b0}}};
                q_d     = '0;
                state_d = S_HOLD;
                if (c_q[0] == '0 || r_q[RW-1]) begin
                    x_d   = '0;
                    err_d = 1'b1;
                end else if (r_q[RW-2:0] >= {1'b0, c_q[0], {SIZE{1'b0}}}) begin
                    x_d   = '1;
                    err_d = 1'b1;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                r_d   = $signed({1'b0, rem_nx});
                div_d = div_q >> 1;
                q_d   = {q_q[SIZE-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(SIZE-1)) begin
                    x_d = {q_q[SIZE-2:0], ge};
`ifdef FIR_INV_STICKY_ERR_EN
                    err_d = err_q | (rem_nx != '0);
`else
                    err_d = (rem_nx != '0);
`endif
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (OUT_READY) begin
                    h_d[2]  = h_q[1];
                    h_d[1]  = h_q[0];
                    h_d[0]  = x_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Clear drops any in-flight sample before it can reach HOLD.
        if (CLR) begin
            state_d = S_IDLE;
            h_d     = '{default: '0};
            x_d     = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '{default: '0};
            h_q     <= '{default: '0};
            cnt_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            x_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            q_q     <= q_d;
            x_q     <= x_d;
            err_q   <= err_d;
        end
    end

    assign IN_READY  = (state_q == S_IDLE);
    assign OUT_VALID = (state_q == S_HOLD);
    assign X_OUT     = x_q;
    assign ERR       = err_q;
endmodule

// File: tb/tb_fir_inverse_dec.sv
// Randomized and directed bench for fir_inverse_dec against an arithmetic deconvolution model.
module tb_fir_inverse_dec;
    localparam int SZ = 8;

    logic            CLK = 1'b0;
    logic            RST, CLR, IN_VALID, OUT_READY;
    logic            IN_READY, OUT_VALID, ERR;
    logic [2*SZ+1:0] Y_IN;
    logic [SZ:0]     C0, C1, C2, C3;
    logic [SZ-1:0]   X_OUT;

    int n_checks = 0;
    int n_fail   = 0;
    int m_h [3];
    int m_sticky = 0;

    fir_inverse_dec #(.SIZE(SZ)) dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .Y_IN(Y_IN), .C0(C0), .C1(C1), .C2(C2), .C3(C3),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .X_OUT(X_OUT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    // Expected result from y = C0*x + C1*h1 + C2*h2 + C3*h3; the emitted value enters the history.
    task automatic model(input int y, input int c0, input int c1, input int c2, input int c3,
                         output int x, output int e, output int lat);
        int r;
        r   = y - c1*m_h[0] - c2*m_h[1] - c3*m_h[2];
        lat = 4;
        e   = 1;
        if (c0 == 0) x = 0;
        else if (r < 0) x = 0;
        else if (r >= c0 * (1 << SZ)) x = (1 << SZ) - 1;
        else begin
            x   = r / c0;
            e   = (r % c0 != 0) ? 1 : 0;
            lat = 4 + SZ;
        end
`ifdef FIR_INV_STICKY_ERR_EN
        e = e | m_sticky;
        m_sticky = e;
`endif
        m_h[2] = m_h[1];
        m_h[1] = m_h[0];
        m_h[0] = x;
    endtask

    function automatic void model_clear();
        m_h = '{0, 0, 0};
        m_sticky = 0;
    endfunction

    // Drives one sample, returns what the DUT produced; bp = cycles of held-off OUT_READY.
    task automatic run_sample(input int y, input int c0, input int c1, input int c2, input int c3,
                              input int bp, output int x, output int e, output int lat,
                              output int steady, output int rdy_after);
        int w;
        @(negedge CLK);
        w = 0;
        while (IN_READY !== 1'b1 && w < 50) begin
            @(negedge CLK);
            w++;
        end
        Y_IN = (2*SZ+2)'(y);
        C0 = (SZ+1)'(c0); C1 = (SZ+1)'(c1); C2 = (SZ+1)'(c2); C3 = (SZ+1)'(c3);
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        Y_IN = (2*SZ+2)'($urandom_range(0, 262143));
        C0 = (SZ+1)'($urandom_range(0, 511)); C1 = (SZ+1)'($urandom_range(0, 511));
        C2 = (SZ+1)'($urandom_range(0, 511)); C3 = (SZ+1)'($urandom_range(0, 511));
        lat = 0;
        while (OUT_VALID !== 1'b1 && lat < 40) begin
            @(posedge CLK);
            lat++;
            #1;
        end
        x = int'(X_OUT);
        e = int'(ERR);
        steady = 1;
        repeat (bp) begin
            @(posedge CLK);
            #1;
            if (X_OUT !== SZ'(x) || ERR !== e[0] || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) steady = 0;
        end
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        rdy_after = (IN_READY === 1'b1 && OUT_VALID === 1'b0) ? 1 : 0;
    endtask

    task automatic test_reset();
        RST = 1'b1; CLR = 1'b0; OUT_READY = 1'b0; IN_VALID = 1'b1;
        Y_IN = 18'd10; C0 = 9'd1; C1 = 9'd0; C2 = 9'd0; C3 = 9'd0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", IN_READY); end
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", OUT_VALID); end
        n_checks++; if (X_OUT !== 8'd0) begin n_fail++; $display("FAIL reset_x_out got %0d exp 0", X_OUT); end
        n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", ERR); end
        @(negedge CLK);
        IN_VALID = 1'b0;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_no_accept got %b exp 1", IN_READY); end
        model_clear();
    endtask

    task automatic test_table(input string nm, input int tbl [][5], input int bp);
        int ex, ee, el, x, e, lat, st, ra;
        foreach (tbl[i]) begin
            model(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], ex, ee, el);
            run_sample(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], bp, x, e, lat, st, ra);
            n_checks++; if (x != ex) begin n_fail++; $display("FAIL %s[%0d] x_out got %0d exp %0d", nm, i, x, ex); end
            n_checks++; if (e != ee) begin n_fail++; $display("FAIL %s[%0d] err got %0d exp %0d", nm, i, e, ee); end
            n_checks++; if (lat != el) begin n_fail++; $display("FAIL %s[%0d] latency got %0d exp %0d", nm, i, lat, el); end
            n_checks++; if (st != 1 || ra != 1) begin n_fail++; $display("FAIL %s[%0d] handshake steady=%0d rdy_after=%0d exp 1/1", nm, i, st, ra); end
        end
    endtask

    task automatic test_exact();
        int t [][5] = '{'{10, 2, 1, 0, 0}, '{19, 2, 1, 0, 0}};
        test_table("exact", t, 0);
    endtask

    task automatic test_zero_c0();
        int t [][5] = '{'{0, 0, 1, 2, 3}, '{5, 1, 1, 0, 0}};
        t[0][0] = $urandom_range(0, 262143);
        test_table("zero_c0", t, 1);
    endtask

    task automatic test_ovf_neg();
        int t [][5] = '{'{300, 1, 0, 0, 0}, '{10, 1, 1, 0, 0}};
        test_table("ovf_neg", t, 0);
    endtask

    task automatic test_remainder();
        int t [][5] = '{'{10, 3, 0, 0, 0}, '{4, 1, 0, 0, 0}};
        test_table("remainder", t, 2);
    endtask

    task automatic test_backpressure();
        int t [][5] = '{'{1000, 7, 2, 1, 3}, '{600, 5, 3, 0, 0}};
        test_table("backpressure", t, 5);
    endtask

    task automatic test_clr_abort();
        int t1 [][5] = '{'{50, 1, 0, 0, 0}};
        int t2 [][5] = '{'{60, 1, 1, 0, 0}};
        int seen;
        test_table("clr_pre", t1, 0);
        @(negedge CLK);
        Y_IN = 18'd77; C0 = 9'd1; C1 = 9'd1; C2 = 9'd1; C3 = 9'd1;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        model_clear();
        seen = 0;
        repeat (20) begin
            @(posedge CLK);
            #1;
            if (OUT_VALID === 1'b1) seen = 1;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL clr_discard out_valid seen %0d exp 0", seen); end
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL clr_idle in_ready got %b exp 1", IN_READY); end
        test_table("clr_post", t2, 0);
    endtask

    task automatic test_rst_abort();
        int t1 [][5] = '{'{40, 1, 0, 0, 0}};
        int t2 [][5] = '{'{9, 1, 1, 1, 1}};
        test_table("rst_pre", t1, 0);
        @(negedge CLK);
        Y_IN = 18'd100; C0 = 9'd2; C1 = 9'd0; C2 = 9'd0; C3 = 9'd0;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (6) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_abort out_valid got %b exp 0", OUT_VALID); end
        n_checks++; if (X_OUT !== 8'd0) begin n_fail++; $display("FAIL rst_abort x_out got %0d exp 0", X_OUT); end
        n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL rst_abort err got %b exp 0", ERR); end
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL rst_abort in_ready got %b exp 1", IN_READY); end
        @(negedge CLK);
        RST = 1'b0;
        model_clear();
        test_table("rst_post", t2, 0);
    endtask

    task automatic test_random();
        int ex, ee, el, x, e, lat, st, ra, bp;
        int c0, c1, c2, c3, y, base;
        for (int i = 0; i < 40; i++) begin
            c0 = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 511);
            c1 = $urandom_range(0, 63);
            c2 = $urandom_range(0, 63);
            c3 = $urandom_range(0, 63);
            base = c1*m_h[0] + c2*m_h[1] + c3*m_h[2];
            if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 262143);
            else y = c0 * $urandom_range(0, 255) + base + $urandom_range(0, (c0 > 0) ? c0 - 1 : 0);
            bp = $urandom_range(0, 3);
            model(y, c0, c1, c2, c3, ex, ee, el);
            run_sample(y, c0, c1, c2, c3, bp, x, e, lat, st, ra);
            n_checks++; if (x != ex) begin n_fail++; $display("FAIL random[%0d] x_out got %0d exp %0d", i, x, ex); end
            n_checks++; if (e != ee) begin n_fail++; $display("FAIL random[%0d] err got %0d exp %0d", i, e, ee); end
            n_checks++; if (lat != el) begin n_fail++; $display("FAIL random[%0d] latency got %0d exp %0d", i, lat, el); end
            n_checks++; if (st != 1 || ra != 1) begin n_fail++; $display("FAIL random[%0d] handshake steady=%0d rdy_after=%0d exp 1/1", i, st, ra); end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_zero_c0();
        test_ovf_neg();
        test_remainder();
        test_backpressure();
        test_clr_abort();
        test_rst_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
